// File: rtl/mcpu_pkg.sv
// Shared opcode constants, FSM state encoding and instruction layout for the mcpu core.
// The optional halt instruction is controlled by the MCPU_HALT_EN macro (see mcpu_core).
package mcpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_SET   = 4'd3;
  localparam logic [3:0] OP_LT    = 4'd4;
  localparam logic [3:0] OP_EQ    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_BNEQ  = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_AND   = 4'd12;
  localparam logic [3:0] OP_OR    = 4'd13;
  localparam logic [3:0] OP_INV   = 4'd14;
  localparam logic [3:0] OP_XOR   = 4'd15;

  localparam logic [2:0] ST_FETCH0 = 3'd0;
  localparam logic [2:0] ST_FETCH1 = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [3:0] HALT_DEST = 4'hF;

  // Second instruction byte doubles as {arg1,arg2} or an 8-bit constant.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] dest;
    logic [3:0] arg1;
    logic [3:0] arg2;
  } instr_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_LT) || (op == OP_EQ) || op[3];
  endfunction

  function automatic logic [7:0] instr_const(input instr_t ir);
    return {ir.arg1, ir.arg2};
  endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU for the mcpu core: compares, add/sub, shifts and bitwise ops.
module mcpu_alu
  import mcpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  // Shift amounts of 8 or more flush the operand completely.
  logic big_shift;
  assign big_shift = (b >= 8'd8);

  always_comb begin
    y = 8'h00;
    case (op)
      OP_LT:   y = {7'd0, (a < b)};
      OP_EQ:   y = {7'd0, (a == b)};
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SHL:  y = big_shift ? 8'h00 : (a << b[2:0]);
      OP_SHR:  y = big_shift ? 8'h00 : (a >> b[2:0]);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_INV:  y = ~a;
      OP_XOR:  y = a ^ b;
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle 8-bit core: two-byte fetch, execute, optional memory cycle on a ready-handshaked bus.
// Define MCPU_HALT_EN to make "NOP r15" (0x0F) stop the core until reset.
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        dout,
  input  logic [7:0]        din,
  input  logic              ready,
  output logic              halted
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  instr_t            ir;
  logic [7:0]        mem_addr;
  logic [7:0]        regs [16];

  logic [7:0] opa, opb, rd, konst, alu_y, ea;
  logic       is_load, is_store, taken, halt_req;
  logic       reg_we;
  logic [7:0] reg_wd;

  assign opa   = regs[ir.arg1];
  assign opb   = regs[ir.arg2];
  assign rd    = regs[ir.dest];
  assign konst = instr_const(ir);
  assign ea    = opa + {4'd0, ir.arg2};

  assign is_load  = (ir.op == OP_LOAD);
  assign is_store = (ir.op == OP_STORE);
  assign taken    = ((ir.op == OP_BEQ)  && (rd == konst)) ||
                    ((ir.op == OP_BNEQ) && (rd != konst));

`ifdef MCPU_HALT_EN
  assign halt_req = (ir.op == OP_NOP) && (ir.dest == HALT_DEST);
  assign halted   = (state == ST_HALT);
`else
  assign halt_req = 1'b0;
  assign halted   = 1'b0;
`endif

  mcpu_alu u_alu (
    .op (ir.op),
    .a  (opa),
    .b  (opb),
    .y  (alu_y)
  );

  // Sequencer: each bus phase waits for ready; EXEC always finishes in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH0;
      pc       <= RESET_PC;
      ir       <= '0;
      mem_addr <= 8'h00;
      dout     <= 8'h00;
    end else begin
      case (state)
        ST_FETCH0: begin
          if (ready) begin
            ir.op   <= din[7:4];
            ir.dest <= din[3:0];
            state   <= ST_FETCH1;
          end
        end
        ST_FETCH1: begin
          if (ready) begin
            ir.arg1 <= din[7:4];
            ir.arg2 <= din[3:0];
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc <= pc + (taken ? ADDR_W'(4) : ADDR_W'(2));
          if (is_load || is_store) begin
            mem_addr <= ea;
            state    <= ST_MEM;
          end else if (halt_req) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH0;
          end
          if (is_store) begin
            dout <= rd;
          end
        end
        ST_MEM: begin
          if (ready) begin
            state <= ST_FETCH0;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH0;
      endcase
    end
  end

  // The register file is deliberately left unreset; an async reset already
  // parks the FSM in FETCH0, which blocks every write path below.
  always_comb begin
    reg_we = 1'b0;
    reg_wd = alu_y;
    if (state == ST_EXEC) begin
      reg_we = (ir.op == OP_SET) || is_alu_op(ir.op);
      reg_wd = (ir.op == OP_SET) ? konst : alu_y;
    end else if (state == ST_MEM) begin
      reg_we = is_load && ready;
      reg_wd = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reg_we) begin
      regs[ir.dest] <= reg_wd;
    end
  end

  always_comb begin
    address = pc;
    case (state)
      ST_FETCH0: address = pc;
      ST_FETCH1: address = pc + ADDR_W'(1);
      ST_MEM:    address = ADDR_W'(mem_addr);
      default:   address = pc;
    endcase
  end

  assign read  = (state == ST_FETCH0) || (state == ST_FETCH1) ||
                 ((state == ST_MEM) && is_load);
  assign write = (state == ST_MEM) && is_store;

endmodule

// File: tb/tb_mcpu_core.sv
// Scoreboard bench for mcpu_core: an instruction-level model predicts the bus transaction
// stream, and a monitor compares every completed DUT request against it.
module tb_mcpu_core;

  localparam int         MSZ = 256;
  localparam logic [7:0] RPC = 8'h00;
`ifdef MCPU_HALT_EN
  localparam bit HALT_BUILD = 1'b1;
`else
  localparam bit HALT_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b1;
  logic       read, write, halted;
  logic [7:0] address, dout, din;

  logic [7:0] mem [MSZ];
  int         mmem [MSZ];
  int         mreg [16];
  bit         mHalted;

  typedef struct {
    bit wr;
    int addr;
    int data;
    int when;
  } txn_t;
  txn_t expQ[$];

  int checks = 0;
  int errors = 0;
  int cyc;
  bit timed = 1'b0;
  int readyMode = 0;
  int stallAddr = 0;
  int stallLeft = 0;
  int holdCnt = 0;
  int writeCnt = 0;

  mcpu_core #(.ADDR_W(8), .RESET_PC(RPC)) dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .address (address),
    .dout    (dout),
    .din     (din),
    .ready   (ready),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  assign din = mem[address];

  always @(posedge clk) begin
    if (!rst && write && ready) mem[address] = dout;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #2;
    case (readyMode)
      0: ready = 1'b1;
      1: ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (!rst && (read || write) && (int'(address) == stallAddr) && stallLeft > 0) begin
          ready = 1'b0;
          stallLeft--;
        end else begin
          ready = 1'b1;
        end
      end
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void pushTxn(input bit wr, input int addr, input int data, input int when);
    txn_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.when = when;
    expQ.push_back(e);
  endfunction

  // Instruction-level reference: executes the program and records the bus traffic it implies.
  task automatic modelRun(input int nInstr);
    int pc, t, b0, b1, op, d, a1, a2, x, y, ea, npc, r;
    pc = int'(RPC);
    t = 0;
    for (int k = 0; k < nInstr && !mHalted; k++) begin
      b0 = mmem[pc];
      b1 = mmem[(pc + 1) % MSZ];
      pushTxn(1'b0, pc, 0, t);
      pushTxn(1'b0, (pc + 1) % MSZ, 0, t + 1);
      op = b0 / 16; d = b0 % 16; a1 = b1 / 16; a2 = b1 % 16;
      x = mreg[a1]; y = mreg[a2];
      ea = (x + a2) % 256;
      npc = pc + 2; r = -1; t += 3;
      case (op)
        0:  if (HALT_BUILD && d == 15) mHalted = 1'b1;
        1:  begin pushTxn(1'b0, ea, 0, t); mreg[d] = mmem[ea]; t++; end
        2:  begin pushTxn(1'b1, ea, mreg[d], t); mmem[ea] = mreg[d]; t++; end
        3:  r = b1;
        4:  r = (x < y) ? 1 : 0;
        5:  r = (x == y) ? 1 : 0;
        6:  if (mreg[d] == b1) npc = pc + 4;
        7:  if (mreg[d] != b1) npc = pc + 4;
        8:  r = (x + y) % 256;
        9:  r = (x + 256 - y) % 256;
        10: r = (y >= 8) ? 0 : (x * (1 << y)) % 256;
        11: r = (y >= 8) ? 0 : x / (1 << y);
        12: r = x & y;
        13: r = x | y;
        14: r = 255 - x;
        default: r = x ^ y;
      endcase
      if (r >= 0) mreg[d] = r;
      pc = npc % MSZ;
    end
  endtask

  logic [7:0] pAddr, pDout;
  logic       pRead, pWrite;
  bit         pWait = 1'b0;
  txn_t       mon;

  // Monitor: protocol invariants every cycle, scoreboard compare on each completed request.
  always @(negedge clk) begin
    if (rst) begin
      pWait = 1'b0;
    end else begin
      checkOutput("rw_exclusive", int'(read && write), 0);
      if (pWait)
        checkOutput("hold_bus", int'({read, write, address, dout}), int'({pRead, pWrite, pAddr, pDout}));
      if ((read || write) && ready && expQ.size() > 0) begin
        mon = expQ.pop_front();
        checkOutput("bus_kind", int'({read, write}), mon.wr ? 1 : 2);
        checkOutput("bus_addr", int'(address), mon.addr);
        if (mon.wr) checkOutput("store_data", int'(dout), mon.data);
        if (timed) checkOutput("bus_cycle", cyc, mon.when);
      end
      pWait  = (read || write) && !ready;
      pRead  = read;
      pWrite = write;
      pAddr  = address;
      pDout  = dout;
      if (read && int'(address) == stallAddr) holdCnt++;
      if (write) writeCnt++;
    end
  end

  task automatic holdReset();
    @(posedge clk);
    #1 rst = 1'b1;
    expQ.delete();
    mHalted = 1'b0;
  endtask

  task automatic clearMem(input bit rnd);
    for (int i = 0; i < MSZ; i++) begin
      mem[i]  = rnd ? 8'($urandom) : 8'h00;
      mmem[i] = int'(mem[i]);
    end
  endtask

  task automatic setByte(input int a, input int v);
    mem[a]  = 8'(v);
    mmem[a] = v;
  endtask

  task automatic applyStimulus(input int mode, input bit isTimed, input int nInstr);
    int budget;
    readyMode = mode;
    timed = isTimed;
    holdCnt = 0;
    writeCnt = 0;
    modelRun(nInstr);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    budget = 0;
    while (expQ.size() != 0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("drain_timeout", expQ.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_read", int'(read), 1);
    checkOutput("reset_write", int'(write), 0);
    checkOutput("reset_halted", int'(halted), 0);
    checkOutput("reset_addr", int'(address), int'(RPC));
    checkOutput("reset_dout", int'(dout), 0);

    // SET r1,5; SET r2,0xFB; ADD r3,r1,r2; STORE r3,[r2+0]
    $display("[TB] program add-wrap");
    holdReset(); clearMem(1'b0);
    setByte(0, 8'h31); setByte(1, 8'h05); setByte(2, 8'h32); setByte(3, 8'hFB);
    setByte(4, 8'h83); setByte(5, 8'h12); setByte(6, 8'h23); setByte(7, 8'h20);
    applyStimulus(0, 1'b1, 4);
    checkOutput("add_wrap_mem", int'(mem[8'hFB]), 0);

    // LOAD r4,[r1+3] with a 3-cycle stall, then STORE r4,[r1+4]
    $display("[TB] stalled load");
    holdReset(); clearMem(1'b0);
    setByte(8'h13, 8'hA5);
    setByte(0, 8'h31); setByte(1, 8'h10); setByte(2, 8'h14); setByte(3, 8'h13);
    setByte(4, 8'h24); setByte(5, 8'h14);
    stallAddr = 8'h13; stallLeft = 3;
    applyStimulus(2, 1'b0, 3);
    checkOutput("load_hold_cycles", holdCnt, 4);
    checkOutput("load_result_mem", int'(mem[8'h14]), 8'hA5);

    // STORE r2,[r1+0] with r1=0x20, r2=0x3C
    $display("[TB] store");
    holdReset(); clearMem(1'b0);
    setByte(0, 8'h31); setByte(1, 8'h20); setByte(2, 8'h32); setByte(3, 8'h3C);
    setByte(4, 8'h22); setByte(5, 8'h10);
    stallAddr = -1;
    applyStimulus(0, 1'b1, 3);
    checkOutput("store_write_cycles", writeCnt, 1);
    checkOutput("store_mem", int'(mem[8'h20]), 8'h3C);

    // BEQ at 0x10, taken and not taken, then taken at the top of the address space
    $display("[TB] branches");
    for (int v = 5; v <= 6; v++) begin
      holdReset(); clearMem(1'b0);
      setByte(0, 8'h31); setByte(1, v);
      setByte(8'h10, 8'h61); setByte(8'h11, 8'h05);
      applyStimulus(0, 1'b1, 10);
    end
    holdReset(); clearMem(1'b0);
    setByte(0, 8'h31); setByte(1, 8'h05);
    setByte(8'hFE, 8'h61); setByte(8'hFF, 8'h05);
    applyStimulus(0, 1'b1, 131);

    // Reset while a STORE is waiting for ready
    $display("[TB] reset during store");
    holdReset(); clearMem(1'b0);
    setByte(8'h20, 8'h55);
    setByte(0, 8'h31); setByte(1, 8'h20); setByte(2, 8'h32); setByte(3, 8'h3C);
    setByte(4, 8'h22); setByte(5, 8'h10);
    stallAddr = 8'h20; stallLeft = 1000;
    applyStimulus(2, 1'b0, 2);
    n = 0;
    while (!write && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("store_pending", int'(write), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_write", int'(write), 0);
    checkOutput("abort_dout", int'(dout), 0);
    checkOutput("abort_addr", int'(address), int'(RPC));
    checkOutput("abort_mem", int'(mem[8'h20]), 8'h55);
    expQ.delete();
    stallLeft = 0;
    applyStimulus(0, 1'b1, 2);
    checkOutput("abort_mem_after", int'(mem[8'h20]), 8'h55);

    // Encoding 0x0F: halt when enabled, plain NOP otherwise
    $display("[TB] nop r15");
    holdReset(); clearMem(1'b0);
    setByte(0, 8'h0F);
`ifdef MCPU_HALT_EN
    applyStimulus(0, 1'b1, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (read || write) n++;
    end
    checkOutput("halt_bus_idle", n, 0);
    checkOutput("halted_set", int'(halted), 1);
`else
    applyStimulus(0, 1'b1, 3);
    checkOutput("halted_tied", int'(halted), 0);
`endif

    // Random programs with every register initialised first, random ready
    for (int s = 0; s < 3; s++) begin
      $display("[TB] random program %0d", s);
      holdReset(); clearMem(1'b1);
      for (int i = 0; i < 16; i++) setByte(2 * i, 8'h30 | i);
      stallAddr = -1;
      applyStimulus(1, 1'b0, 120);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_core.md
MCPU_CORE -- requirements
Module: mcpu_core

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning bus address width (legal 8..16).
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-003 The block SHALL have port clk  input  1  clock, all state updated on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; the reset is asynchronous and active-high.
REQ-005 The block SHALL have port read  output  1  bus read request (fetch or load).
REQ-006 The block SHALL have port write  output  1  bus write request (store).
REQ-007 The block SHALL have port address  output  ADDR_W  bus address.
REQ-008 The block SHALL have port dout  output  8  write data.
REQ-009 The block SHALL have port din  input  8  read data, valid when ready=1.
REQ-010 The block SHALL have port ready  input  1  bus completion; a request ends on the rising edge where ready=1.
REQ-011 The block SHALL have port halted  output  1  core stopped.

Function
REQ-012 The block SHALL hold 16 registers of 8 bits (r0..r15) and a separate ADDR_W-bit PC.
REQ-013 Instructions SHALL be 2 bytes: byte at PC = {op[7:4],dest[3:0]}, byte at PC+1 = {arg1,arg2} or an 8-bit constant.
REQ-014 The FSM SHALL have states FETCH0, FETCH1, EXEC, MEM, HALT; transitions: FETCH0->FETCH1 on ready, FETCH1->EXEC on ready, EXEC->MEM for LOAD/STORE, else EXEC->FETCH0, MEM->FETCH0 on ready.
REQ-015 read SHALL be 1 in FETCH0, FETCH1 and MEM-for-LOAD; write SHALL be 1 only in MEM-for-STORE; read and write SHALL never both be 1.
REQ-016 address, dout, read, write SHALL stay constant while a request waits for ready.
REQ-017 address SHALL be PC in FETCH0, PC+1 in FETCH1, and zero-extended (r[arg1]+arg2) mod 2^8 in MEM.
REQ-018 With ready held 1, non-memory instructions SHALL take 3 cycles and LOAD/STORE 4 cycles.
REQ-019 PC SHALL advance by 2 in EXEC; BEQ/BNEQ SHALL advance it by 4 when taken; PC arithmetic SHALL wrap mod 2^ADDR_W.
REQ-020 Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 SET, 4 LT (unsigned, result 0/1), 5 EQ (0/1), 6 BEQ r[dest]==const, 7 BNEQ r[dest]!=const, 8 ADD, 9 SUB, 10 SHL, 11 SHR, 12 AND, 13 OR, 14 INV, 15 XOR.
REQ-021 ALU results SHALL be 8-bit, carry/borrow discarded; shift amounts >=8 SHALL give 0.
REQ-022 ALU and SET results SHALL be written to r[dest] on the EXEC edge; LOAD data SHALL be written on the MEM edge where ready=1.
REQ-023 STORE SHALL drive dout=r[dest] for the whole MEM state.
REQ-024 When dest equals arg1 or arg2, operands SHALL be the pre-write register values.

Reset
REQ-025 On rst=1, asynchronously: state=FETCH0, PC=RESET_PC, write=0, halted=0, dout=0; r0..r15 SHALL NOT be reset.
REQ-026 Reset mid-request SHALL abort it with no register or PC update; the first post-reset request SHALL be a fetch at RESET_PC.

Configuration
REQ-027 Macro MCPU_HALT_EN defined: NOP with dest=4'hF SHALL enter HALT (read=write=0, halted=1) until reset.
REQ-028 Macro MCPU_HALT_EN undefined: that encoding SHALL be a plain NOP, HALT unreachable, halted tied 0.

Structure
REQ-029 Opcode constants and the FSM state encoding SHALL live in package mcpu_pkg.
REQ-030 The ALU (ops 4,5,8..15) SHALL be a combinational sub-module mcpu_alu.

Verification
REQ-031 Program "SET r1,0x05; SET r2,0xFB; ADD r3,r1,r2" with ready=1 -> r3=0x00, 9 cycles.
REQ-032 LOAD r4,[r1+3] with r1=0x10, mem[0x13]=0xA5, ready low 3 cycles in MEM -> address 0x13 held 4 cycles, r4=0xA5 after.
REQ-033 STORE r2 to [r1+0] with r2=0x3C, r1=0x20 -> write=1 one cycle, address 0x20, dout 0x3C, read=0.
REQ-034 BEQ r1,0x05 at PC 0x10 with r1=0x05 -> next fetch at 0x14; with r1=0x06 -> 0x12; at PC 0xFE, ADDR_W=8, taken -> 0x02.
REQ-035 rst asserted during a waiting STORE -> write drops immediately, memory and PC unchanged, next fetch at RESET_PC.
REQ-036 With MCPU_HALT_EN, opcode 0x0F -> halted=1, no further bus requests for 20 cycles; without it -> fetch continues at PC+2.
